// File: rtl/mult_accumulate_stage.sv
// mult_accumulate_stage: sums a programmed number of 64-bit signed products
// from the 32x32 multiplier into an ACC_W-bit accumulator. The final sum,
// the beat count and a sticky overflow flag are returned over a valid/ready
// handshake.
// Optional build macro: MAC_SATURATE_EN. When defined, the accumulator clamps
// to its most positive or most negative value on overflow. When undefined, the
// accumulator wraps in two's complement. The sticky overflow flag is set in
// both builds.
module mult_accumulate_stage #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [63:0]      prod_data,
  input  logic             prod_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic [CNT_W-1:0] res_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   sum_w;
  logic signed [ACC_W-1:0] sum_trunc;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] acc_beat;

  // Sign-extend the incoming product to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [63:0] p);
    return ACC_W'(p);
  endfunction

`ifdef MAC_SATURATE_EN
  // Clamp value for an overflowed add. The direction follows the operand sign,
  // because overflow only happens when both operands share a sign.
  function automatic logic signed [ACC_W-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction
`endif

  assign prod_ext  = sext_prod(prod_data);
  assign sum_w     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
  assign sum_trunc = sum_w[ACC_W-1:0];
  // When the operand signs are equal and the result sign differs, the top two
  // bits of the one-bit-wider sum disagree.
  assign add_ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];

`ifdef MAC_SATURATE_EN
  assign acc_beat = add_ovf ? sat_value(prod_ext[ACC_W-1]) : sum_trunc;
`else
  assign acc_beat = sum_trunc;
`endif

  // Next state and datapath update for the IDLE -> ACCUM -> DONE job sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          rem_d   = len;
          state_d = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_d = acc_beat;
          ovf_d = ovf_q | prod_ovf | add_ovf;
          cnt_d = cnt_q + CNT_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // The handshake outputs decode the state register only. The result fields
  // come straight from registers, so they hold stable while DONE waits.
  assign prod_ready = (state_q == ACCUM);
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign res_data   = acc_q;
  assign res_ovf    = ovf_q;
  assign res_count  = cnt_q;

endmodule

// File: tb/tb_mult_accumulate_stage.sv
// tb_mult_accumulate_stage: directed vectors for mult_accumulate_stage.
// Two instances share the same inputs: one with the default 72-bit accumulator
// and one with a 64-bit accumulator, which exercises the overflow and clamping
// behaviour.
module tb_mult_accumulate_stage;

  localparam int CNT_W = 8;
`ifdef MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start, prod_valid, prod_ovf, res_ready;
  logic [CNT_W-1:0] len;
  logic [63:0]      prod_data;

  logic             pr72, rv72, ro72, bz72;
  logic [71:0]      rd72;
  logic [CNT_W-1:0] rc72;
  logic             pr64, rv64, ro64, bz64;
  logic [63:0]      rd64;
  logic [CNT_W-1:0] rc64;

  int n_checks = 0;
  int n_fail   = 0;

  mult_accumulate_stage #(.ACC_W(72), .CNT_W(CNT_W)) dut72 (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_ready(pr72), .prod_data(prod_data), .prod_ovf(prod_ovf),
    .res_valid(rv72), .res_ready(res_ready), .res_data(rd72), .res_ovf(ro72),
    .res_count(rc72), .busy(bz72));

  mult_accumulate_stage #(.ACC_W(64), .CNT_W(CNT_W)) dut64 (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_ready(pr64), .prod_data(prod_data), .prod_ovf(prod_ovf),
    .res_valid(rv64), .res_ready(res_ready), .res_data(rd64), .res_ovf(ro64),
    .res_count(rc64), .busy(bz64));

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]  len;
    logic [3:0][63:0]  p;
    logic [3:0]        o;
    logic [71:0]       e72;
    logic              o72;
    logic [63:0]       e64w;
    logic [63:0]       e64s;
    logic              o64;
  } vec_t;

  vec_t vt[7];

  function automatic vec_t mk(input logic [CNT_W-1:0] l, input logic [63:0] p0, input logic [63:0] p1,
                              input logic [63:0] p2, input logic [63:0] p3, input logic [3:0] o,
                              input logic [71:0] e72, input logic o72, input logic [63:0] e64w,
                              input logic [63:0] e64s, input logic o64);
    vec_t v;
    v.len = l; v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3; v.o = o;
    v.e72 = e72; v.o72 = o72; v.e64w = e64w; v.e64s = e64s; v.o64 = o64;
    return v;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " rv72"}, 72'(rv72), 72'(0));
    chk({tag, " pr72"}, 72'(pr72), 72'(0));
    chk({tag, " bz72"}, 72'(bz72), 72'(0));
    chk({tag, " rd72"}, rd72, 72'(0));
    chk({tag, " ro72"}, 72'(ro72), 72'(0));
    chk({tag, " rc72"}, 72'(rc72), 72'(0));
    chk({tag, " rv64"}, 72'(rv64), 72'(0));
    chk({tag, " pr64"}, 72'(pr64), 72'(0));
    chk({tag, " rd64"}, 72'(rd64), 72'(0));
    chk({tag, " rc64"}, 72'(rc64), 72'(0));
  endtask

  task automatic run_job(input vec_t v, input string tag);
    start = 1'b1; len = v.len;
    step();
    start = 1'b0;
    chk({tag, " busy"}, 72'(bz72 & bz64), 72'(1));
    for (int i = 0; i < int'(v.len); i++) begin
      chk({tag, " prod_ready"}, 72'({pr72, pr64}), 72'(3));
      prod_valid = 1'b1; prod_data = v.p[i]; prod_ovf = v.o[i];
      step();
    end
    prod_valid = 1'b0; prod_ovf = 1'b0;
    chk({tag, " res_valid latency"}, 72'({rv72, rv64}), 72'(3));
    for (int k = 0; k < 8 && !(rv72 && rv64); k++) step();
    chk({tag, " rd72"}, rd72, v.e72);
    chk({tag, " ro72"}, 72'(ro72), 72'(v.o72));
    chk({tag, " rc72"}, 72'(rc72), 72'(v.len));
    chk({tag, " rd64"}, 72'(rd64), 72'(SAT ? v.e64s : v.e64w));
    chk({tag, " ro64"}, 72'(ro64), 72'(v.o64));
    chk({tag, " rc64"}, 72'(rc64), 72'(v.len));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, " rv after handshake"}, 72'({rv72, rv64}), 72'(0));
    chk({tag, " busy after handshake"}, 72'({bz72, bz64}), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0;
    prod_data = '0; prod_ovf = 1'b0; res_ready = 1'b0;

    vt[0] = mk(3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd0, 4'b0000,
               72'd98, 1'b0, 64'd98, 64'd98, 1'b0);
    vt[1] = mk(1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd0, 64'd0, 4'b0000,
               72'hFF_FFFF_FFFF_FFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    vt[2] = mk(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 4'b0000,
               72'h00_8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    vt[3] = mk(2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 4'b0000,
               72'hFF_7FFF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1);
    vt[4] = mk(2, 64'd10, 64'd20, 64'd0, 64'd0, 4'b0010,
               72'd30, 1'b1, 64'd30, 64'd30, 1'b1);
    vt[5] = mk(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 4'b0000,
               72'h00_FFFF_FFFF_FFFF_FFF9, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h7FFF_FFFF_FFFF_FFFA, 1'b1);
    vt[6] = mk(4, 64'd1, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFF6, 4'b0000,
               72'hFF_FFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

    step(); step();
    chk_idle_zero("reset");
    reset = 1'b0;
    step();

    for (int n = 0; n < 7; n++) run_job(vt[n], $sformatf("vec%0d", n));

    // Gapped products, held result under backpressure, start during the handshake.
    start = 1'b1; len = 2;
    step();
    start = 1'b0;
    prod_valid = 1'b1; prod_data = 64'd40;
    step();
    prod_valid = 1'b0;
    step(); step();
    chk("gap res_valid", 72'({rv72, rv64}), 72'(0));
    chk("gap busy", 72'({bz72, bz64}), 72'(3));
    chk("gap count", 72'(rc72), 72'(1));
    prod_valid = 1'b1; prod_data = 64'hFFFF_FFFF_FFFF_FFF1;
    step();
    prod_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp res_valid", 72'({rv72, rv64}), 72'(3));
      chk("bp rd72", rd72, 72'd25);
      chk("bp rd64", 72'(rd64), 72'd25);
      chk("bp count", 72'(rc72), 72'(2));
      step();
    end
    res_ready = 1'b1; start = 1'b1; len = 1;
    step();
    res_ready = 1'b0; start = 1'b0;
    chk("bp release rv", 72'({rv72, rv64}), 72'(0));
    chk("bp release busy", 72'({bz72, bz64}), 72'(0));
    chk("bp hold rd72", rd72, 72'd25);
    step();
    chk("start in DONE ignored", 72'({bz72, bz64, pr72, pr64}), 72'(0));

    // Zero-length job.
    start = 1'b1; len = 0;
    step();
    start = 1'b0;
    chk("zero rv", 72'({rv72, rv64}), 72'(3));
    chk("zero rd72", rd72, 72'(0));
    chk("zero rc72", 72'(rc72), 72'(0));
    chk("zero pr", 72'({pr72, pr64}), 72'(0));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("zero done rv", 72'({rv72, rv64, pr72, pr64}), 72'(0));

    // Reset in the middle of a job, with a product still being offered.
    start = 1'b1; len = 4;
    step();
    start = 1'b0;
    prod_valid = 1'b1; prod_data = 64'd1;
    step();
    prod_data = 64'd2;
    step();
    prod_data = 64'd7; reset = 1'b1;
    step();
    reset = 1'b0; prod_valid = 1'b0;
    chk_idle_zero("midreset");
    run_job(vt[1], "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_accumulate_stage.md
Name: mult_accumulate_stage

Overview:
- Downstream consumer of the 32x32 signed multiplier.
- Accepts a stream of 64-bit signed products over a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Presents the final sum, with a sticky overflow flag, on a second valid/ready handshake.
- Used for dot-product and multiply-accumulate operations in the ALU explorer datapath.

Parameters:
ACC_W, 72, accumulator/result width in bits; must be >= 64 (8 guard bits by default)
CNT_W, 8, width of the length field and the beat counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to begin a new accumulation; honoured only in IDLE
len  input  CNT_W  number of products to sum; sampled when start is honoured
prod_valid  input  1  upstream product valid
prod_ready  output  1  stage can accept a product
prod_data  input  64  signed product, two's complement
prod_ovf  input  1  upstream multiplier overflow flag, qualified by prod_valid
res_valid  output  1  final result available
res_ready  input  1  downstream accepts result
res_data  output  ACC_W  signed accumulated sum
res_ovf  output  1  sticky: accumulator overflow or any prod_ovf seen during the job
res_count  output  CNT_W  number of products actually summed (equals len)
busy  output  1  high in ACCUM or DONE

Behaviour:
- Synchronous reset (sampled on the rising clk edge), values after reset:
  - state = IDLE
  - accumulator = 0, remaining = 0, count = 0, sticky ovf = 0
  - outputs: prod_ready = 0, res_valid = 0, res_data = 0, res_ovf = 0, res_count = 0, busy = 0
- Reset asserted mid-operation aborts the job with no result; any in-flight product is dropped.
- States:
  - IDLE: prod_ready = 0, res_valid = 0.
    - On start: acc <- 0, ovf <- 0, count <- 0, remaining <- len.
    - If len != 0, next state ACCUM; if len == 0, next state DONE, producing res_data = 0 and res_count = 0.
  - ACCUM: prod_ready = 1.
    - A beat is accepted when prod_valid && prod_ready.
    - On each accepted beat: acc <- acc + sign_extend(prod_data, ACC_W); ovf <- ovf | prod_ovf | add_overflow; count++; remaining--.
    - When a beat is accepted with remaining == 1, next state is DONE.
    - Cycles without prod_valid change nothing.
  - DONE: res_valid = 1; res_data, res_ovf and res_count are driven from registers and held stable until res_valid && res_ready.
    - On that handshake, next state IDLE. res_data holds its value afterwards; res_valid drops.
- start is ignored outside IDLE. start and res_ready arriving in the same cycle in DONE: return to IDLE only; the start is not honoured.
- Latency: res_valid rises on the clock edge that accepts the final beat, so it is visible the cycle after that beat. Throughput is one product per cycle in ACCUM.
- Arithmetic:
  - Sum computed at ACC_W+1 bits.
  - add_overflow = operand signs equal && result sign differs from them.
  - Without saturation the result wraps to ACC_W bits.
- len is interpreted as unsigned; maximum 2^CNT_W - 1 beats.
- prod_ready is a registered function of state only; it does not depend combinationally on prod_valid.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined:
  - On add_overflow, acc is clamped to the most positive value (2^(ACC_W-1) - 1) for positive overflow, or the most negative value (-2^(ACC_W-1)) for negative overflow.
  - Accumulation continues from the clamped value; the ovf sticky is set.
- Not defined: two's-complement wrap-around, ovf sticky is still set; no clamp logic is synthesised.

Test Plan:
- Basic sum: start, len=3, products 5, -7, 100 (prod_valid held high) -> res_valid on the cycle after the 3rd beat; res_data = 98, res_count = 3, res_ovf = 0.
- Backpressure and stalls: len=2, prod_valid gapped (1,0,0,1), res_ready held low for 4 cycles -> res_data = sum, stable while res_valid && !res_ready; returns to IDLE one cycle after res_ready = 1.
- Zero length: start with len=0 -> DONE on the next cycle with res_data = 0, res_count = 0; prod_ready never asserted.
- Overflow, ACC_W=64: products 0x7FFF_FFFF_FFFF_FFFF then 1 -> res_ovf = 1. With MAC_SATURATE_EN, res_data = 0x7FFF_FFFF_FFFF_FFFF; without it, res_data = 0x8000_0000_0000_0000.
- Upstream overflow propagation: len=2, second beat carries prod_ovf = 1 -> res_ovf = 1 and res_data = correct sum.
- Reset mid-job: len=4, assert reset after 2 beats -> next cycle all outputs 0, state IDLE. A new start with len=1, product -3 -> res_data = -3.
